// File: rtl/hash_pkg.sv
// hash_pkg: block geometry, hash width and loader state encoding shared by the xor_hash path.
package hash_pkg;
  localparam int BLOCK_W = 512;
  localparam int HASH_W = 8;
  typedef logic [BLOCK_W-1:0] hash_block_t;
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/xor_hash_block_loader.sv
// xor_hash_block_loader: packs a 32-bit word stream into zero-padded 512-bit blocks for xor_hash.
module xor_hash_block_loader #(
  parameter int WORD_W = 32,
  parameter int BLOCK_W = 512,
  parameter int WORDS = BLOCK_W / WORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [4:0]         out_words,
  output logic [15:0]        blocks_sent
);
  import hash_pkg::*;
  localparam int PW = $clog2(WORDS);
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, wptr;
  logic [BLOCK_W-1:0] blk_q, blk_d, base;
  logic [4:0] words_q, words_d;
  logic last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic acc, cons, close;
  assign out_valid = state_q == FULL;
  assign in_ready = rst_n & (out_valid ? out_ready : 1'b1);
  assign out_block = blk_q;
  assign out_words = words_q;
  assign out_last = last_q;
  assign blocks_sent = cnt_q;
  always_comb begin
    acc = in_valid & in_ready;
    cons = out_valid & out_ready;
    // A word accepted while FULL always coincides with consumption and opens the next block at slot 0.
    wptr = out_valid ? '0 : ptr_q;
    close = acc & (in_last | (!out_valid & ptr_q == PW'(WORDS - 1)));
    state_d = close ? FULL : (cons ? FILL : state_q);
    ptr_d = cons ? PW'(acc) : ((acc & !close) ? ptr_q + 1'b1 : ptr_q);
    words_d = close ? 5'(wptr) + 5'd1 : words_q;
    last_d = close ? in_last : last_q;
    cnt_d = cnt_q + 16'(cons);
    base = cons ? '0 : blk_q;
    blk_d = base;
    for (int k = 0; k < WORDS; k++)
      if (acc && wptr == PW'(k)) blk_d[BLOCK_W-1-k*WORD_W -: WORD_W] = in_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      ptr_q <= '0;
      blk_q <= '0;
      words_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      blk_q <= blk_d;
      words_q <= words_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_xor_hash_block_loader.sv
// tb_xor_hash_block_loader: directed scenario tasks with hand-computed expectations.
module tb_xor_hash_block_loader;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_last;
  logic [511:0] out_block, snap;
  logic [4:0] out_words;
  logic [15:0] blocks_sent;
  int vecs = 0, errs = 0;

  xor_hash_block_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_words(out_words), .blocks_sent(blocks_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_data = 32'hFFFF_FFFF; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready c%0d got %b exp 0", c, in_ready); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid c%0d got %b exp 0", c, out_valid); end
      vecs++; if (out_words !== 5'd0) begin errs++; $display("FAIL reset_out_words c%0d got %0d exp 0", c, out_words); end
      vecs++; if (blocks_sent !== 16'd0) begin errs++; $display("FAIL reset_blocks_sent c%0d got %0d exp 0", c, blocks_sent); end
    end
    in_valid = 0; rst_n = 1;
    tick();
  endtask

  task automatic test_full_block();
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1; in_data = 32'(i); in_last = (i == 16);
      #1;
      vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL full_fill w%0d got valid=%b ready=%b exp valid=0 ready=1", i, out_valid, in_ready); end
      tick();
    end
    in_valid = 0; in_last = 0;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL full_valid got %b exp 1", out_valid); end
    vecs++; if (out_block[511:480] !== 32'h1) begin errs++; $display("FAIL full_first got %h exp 00000001", out_block[511:480]); end
    vecs++; if (out_block[31:0] !== 32'h10) begin errs++; $display("FAIL full_last_word got %h exp 00000010", out_block[31:0]); end
    for (int k = 0; k < 16; k++) begin
      vecs++; if (out_block[511-k*32 -: 32] !== 32'(k + 1)) begin errs++; $display("FAIL full_slot%0d got %h exp %h", k, out_block[511-k*32 -: 32], 32'(k + 1)); end
    end
    vecs++; if (out_words !== 5'd16 || out_last !== 1'b1) begin errs++; $display("FAIL full_meta got words=%0d last=%b exp 16/1", out_words, out_last); end
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL full_one_cycle got %b exp 0", out_valid); end
    vecs++; if (blocks_sent !== 16'd1) begin errs++; $display("FAIL full_count got %0d exp 1", blocks_sent); end
  endtask

  task automatic test_short();
    logic [31:0] w [3];
    w[0] = 32'hDEADBEEF; w[1] = 32'h12345678; w[2] = 32'hA5A5A5A5;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = w[i]; in_last = (i == 2);
      tick();
    end
    in_valid = 0; in_last = 0;
    vecs++; if (out_block[511:416] !== 96'hDEADBEEF_12345678_A5A5A5A5) begin errs++; $display("FAIL short_words got %h", out_block[511:416]); end
    vecs++; if (out_block[415:0] !== 416'd0) begin errs++; $display("FAIL short_pad got nonzero exp 0"); end
    vecs++; if (out_words !== 5'd3 || out_last !== 1'b1 || out_valid !== 1'b1) begin errs++; $display("FAIL short_meta got words=%0d last=%b valid=%b exp 3/1/1", out_words, out_last, out_valid); end
    tick();
    vecs++; if (blocks_sent !== 16'd2) begin errs++; $display("FAIL short_count got %0d exp 2", blocks_sent); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1; in_data = 32'hAAAA0001; in_last = 0; tick();
    in_data = 32'hAAAA0002; in_last = 1; tick();
    snap = out_block;
    in_data = 32'hCCCC0003; in_last = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready c%0d got %b exp 0", c, in_ready); end
      vecs++; if (out_block !== snap || out_valid !== 1'b1 || out_words !== 5'd2) begin errs++; $display("FAIL bp_stable c%0d got valid=%b words=%0d", c, out_valid, out_words); end
      tick();
    end
    vecs++; if (snap[511:448] !== 64'hAAAA0001_AAAA0002) begin errs++; $display("FAIL bp_block got %h exp aaaa0001aaaa0002", snap[511:448]); end
    out_ready = 1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    vecs++; if (out_valid !== 1'b0 || out_block[511:480] !== 32'hCCCC0003 || out_block[479:0] !== 480'd0) begin errs++; $display("FAIL bp_slot0 got valid=%b slot0=%h", out_valid, out_block[511:480]); end
    vecs++; if (blocks_sent !== 16'd3) begin errs++; $display("FAIL bp_count got %0d exp 3", blocks_sent); end
    in_data = 32'hDDDD0004; in_last = 1; tick();
    in_valid = 0; in_last = 0;
    vecs++; if (out_block[511:448] !== 64'hCCCC0003_DDDD0004 || out_block[447:0] !== 448'd0 || out_words !== 5'd2) begin errs++; $display("FAIL bp_next got %h words=%0d", out_block[511:448], out_words); end
    tick();
    vecs++; if (blocks_sent !== 16'd4) begin errs++; $display("FAIL bp_next_count got %0d exp 4", blocks_sent); end
  endtask

  task automatic test_single_words();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_last = 1; in_data = 32'h100 + 32'(i);
      tick();
      vecs++; if (out_valid !== 1'b1 || out_words !== 5'd1 || out_last !== 1'b1) begin errs++; $display("FAIL single%0d_meta got valid=%b words=%0d last=%b", i, out_valid, out_words, out_last); end
      vecs++; if (out_block[511:480] !== 32'h100 + 32'(i) || out_block[479:0] !== 480'd0) begin errs++; $display("FAIL single%0d_block got %h", i, out_block[511:480]); end
      vecs++; if (blocks_sent !== 16'(4 + i)) begin errs++; $display("FAIL single%0d_count got %0d exp %0d", i, blocks_sent, 4 + i); end
    end
    in_valid = 0; in_last = 0;
    tick();
    vecs++; if (blocks_sent !== 16'd8 || out_valid !== 1'b0) begin errs++; $display("FAIL single_drain got count=%0d valid=%b exp 8/0", blocks_sent, out_valid); end
  endtask

  task automatic test_abort();
    out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_last = 0; in_data = 32'hBAD00000 + 32'(i); tick();
    end
    in_valid = 0; rst_n = 0; tick();
    vecs++; if (out_valid !== 1'b0 || blocks_sent !== 16'd0 || out_block !== 512'd0) begin errs++; $display("FAIL abort_reset got valid=%b count=%0d", out_valid, blocks_sent); end
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_last = (i == 15); in_data = 32'h1000 + 32'(i); tick();
      if (i < 15) begin
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL abort_early_valid w%0d got 1 exp 0", i); end
      end
    end
    in_valid = 0; in_last = 0;
    for (int k = 0; k < 16; k++) begin
      vecs++; if (out_block[511-k*32 -: 32] !== 32'h1000 + 32'(k)) begin errs++; $display("FAIL abort_slot%0d got %h exp %h", k, out_block[511-k*32 -: 32], 32'h1000 + 32'(k)); end
    end
    vecs++; if (out_words !== 5'd16 || out_last !== 1'b1) begin errs++; $display("FAIL abort_meta got words=%0d last=%b", out_words, out_last); end
    tick();
    vecs++; if (blocks_sent !== 16'd1) begin errs++; $display("FAIL abort_count got %0d exp 1", blocks_sent); end
  endtask

  task automatic test_wrap();
    rst_n = 0; in_valid = 0; tick();
    rst_n = 1; out_ready = 1; in_valid = 1; in_last = 1; in_data = 32'h5;
    repeat (65536) @(posedge clk);
    #1;
    vecs++; if (blocks_sent !== 16'hFFFF || out_valid !== 1'b1) begin errs++; $display("FAIL wrap_preload got count=%0d valid=%b exp 65535/1", blocks_sent, out_valid); end
    in_valid = 0; in_last = 0;
    tick();
    vecs++; if (blocks_sent !== 16'd0) begin errs++; $display("FAIL wrap_zero got %0d exp 0", blocks_sent); end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_short();
    test_backpressure();
    test_single_words();
    test_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
